// File: rtl/mfp_bot_upd_arb.sv
// Two-rojobot update arbiter: round-robin grant to the CPU, int_ack pulse per bot.
// Define MFP_BOT_ARB_TIMEOUT_EN to abandon grants not acknowledged within ACK_TIMEOUT cycles.
module mfp_bot_upd_arb #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        upd_req0,
  input  logic        upd_req1,
  input  logic [31:0] bot_info0,
  input  logic [31:0] bot_info1,
  input  logic        cpu_ack,
  input  logic        ovr_clr,
  output logic        grant_valid,
  output logic        grant_id,
  output logic [31:0] grant_info,
  output logic        int_ack0,
  output logic        int_ack1,
  output logic [1:0]  overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ACK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_req_prev;
  logic        r_armed;
  logic [1:0]  r_pending;
  logic [1:0]  r_overrun;
  logic        r_last;
  logic        r_gv;
  logic        r_gid;
  logic [31:0] r_ginfo;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_to;

  logic [1:0]  w_req;
  logic [1:0]  w_rise;
  logic [1:0]  w_pend_clr;
  logic [1:0]  w_pend_nxt;
  logic [1:0]  w_ovr_nxt;
  logic        w_win;
  logic        w_last_nxt;
  logic        w_gv_nxt;
  logic        w_gid_nxt;
  logic [31:0] w_ginfo_nxt;
  logic        w_ack0_nxt;
  logic        w_ack1_nxt;
  logic        w_to_nxt;
  logic        w_expire;

  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end

  // r_armed masks the first edge after reset so a held level is not a rise
  assign w_req  = {upd_req1, upd_req0};
  assign w_rise = w_req & ~r_req_prev & {2{r_armed}};

`ifdef MFP_BOT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_expire  = (r_state == S_GRANT) && !cpu_ack &&
                     (w_cnt_inc == CW'(ACK_TIMEOUT));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
    end else if (r_state != S_GRANT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pend_clr  = 2'b00;
    w_win       = 1'b0;
    w_last_nxt  = r_last;
    w_gv_nxt    = r_gv;
    w_gid_nxt   = r_gid;
    w_ginfo_nxt = r_ginfo;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_to_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_win       = (&r_pending) ? ~r_last : r_pending[1];
          w_gv_nxt    = 1'b1;
          w_gid_nxt   = w_win;
          w_ginfo_nxt = w_win ? bot_info1 : bot_info0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (cpu_ack) begin
          w_state_nxt       = S_ACK;
          w_gv_nxt          = 1'b0;
          w_pend_clr[r_gid] = 1'b1;
          w_last_nxt        = r_gid;
          w_ack0_nxt        = ~r_gid;
          w_ack1_nxt        = r_gid;
        end else if (w_expire) begin
          w_state_nxt       = S_IDLE;
          w_gv_nxt          = 1'b0;
          w_pend_clr[r_gid] = 1'b1;
          w_last_nxt        = r_gid;
          w_to_nxt          = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // a new rise beats a same-cycle clear, for both pending and overrun
  assign w_pend_nxt = (r_pending & ~w_pend_clr) | w_rise;
  assign w_ovr_nxt  = (r_overrun & ~{2{ovr_clr}}) |
                      (w_rise & r_pending & ~w_pend_clr);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_req_prev <= 2'b00;
      r_armed    <= 1'b0;
      r_pending  <= 2'b00;
      r_overrun  <= 2'b00;
      r_last     <= 1'b1;
      r_gv       <= 1'b0;
      r_gid      <= 1'b0;
      r_ginfo    <= 32'h0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_prev <= w_req;
      r_armed    <= 1'b1;
      r_pending  <= w_pend_nxt;
      r_overrun  <= w_ovr_nxt;
      r_last     <= w_last_nxt;
      r_gv       <= w_gv_nxt;
      r_gid      <= w_gid_nxt;
      r_ginfo    <= w_ginfo_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_to       <= w_to_nxt;
    end
  end

  assign grant_valid = r_gv;
  assign grant_id    = r_gid;
  assign grant_info  = r_ginfo;
  assign int_ack0    = r_ack0;
  assign int_ack1    = r_ack1;
  assign overrun     = r_overrun;
  assign timeout     = r_to;

endmodule

// File: doc/mfp_bot_upd_arb.md
MFP_BOT_UPD_ARB -- requirements
Module: mfp_bot_upd_arb

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 1023, maximum HCLK cycles a grant waits for the CPU acknowledge (TIMEOUT_EN builds only).
REQ-002 Port: HCLK  in  1  sole clock; all logic on its rising edge.
REQ-003 Port: HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: upd_req0 / upd_req1  in  1 each  rojobot update-sync levels, already synchronous to HCLK.
REQ-005 Port: bot_info0 / bot_info1  in  32 each  rojobot status words.
REQ-006 Port: cpu_ack  in  1  one-cycle pulse from the GPIO IntAck register write.
REQ-007 Port: ovr_clr  in  1  one-cycle pulse; clears the overrun flags.
REQ-008 Port: grant_valid  out  1  a bot update is presented to the CPU.
REQ-009 Port: grant_id  out  1  bot being presented (0 or 1).
REQ-010 Port: grant_info  out  32  snapshot of the granted bot's info word.
REQ-011 Port: int_ack0 / int_ack1  out  1 each  one-cycle acknowledge pulse to the corresponding rojobot.
REQ-012 Port: overrun  out  2  sticky per-bot lost-update flags.
REQ-013 Port: timeout  out  1  one-cycle pulse when a grant is abandoned.

Function
REQ-014 Rise detect: bit i rises at an edge where upd_req_i=1 and the registered previous value is 0; on that edge pending[i] is set.
REQ-015 FSM states: IDLE, GRANT, ACK; all outputs registered.
REQ-016 IDLE: if any pending bit is set, select a winner, load grant_id and grant_info (bot_info of the winner sampled that cycle), set grant_valid, and enter GRANT on the same edge.
REQ-017 Arbitration: round-robin; with both pending, the winner is the bot not served last; last_served resets to 1, so bot 0 wins first.
REQ-018 GRANT: grant_valid stays 1 and grant_info is held stable; cpu_ack=1 enters ACK.
REQ-019 Entering ACK: grant_valid clears, pending[grant_id] clears, int_ack[grant_id] pulses high for exactly one cycle, and last_served is set to grant_id.
REQ-020 ACK: the FSM returns to IDLE on the next edge.
REQ-021 Latency: the edge after a detected rise asserts grant_valid when the FSM is IDLE.
REQ-022 Minimum spacing between consecutive grants is 3 cycles.
REQ-023 cpu_ack outside GRANT is ignored and has no side effects.
REQ-024 A rise on bot i while pending[i] is already set sets overrun[i]; no second event is queued.
REQ-025 A rise on bot i in the same cycle pending[i] clears leaves pending[i] set (set wins), with no overrun.
REQ-026 ovr_clr coincident with a new overrun condition leaves that overrun bit set (set wins).
REQ-027 int_ack0 and int_ack1 are never high in the same cycle.

Reset
REQ-028 Asserting HRESETn low, at any time including mid-grant, forces IDLE, pending=0, rise history=0, and last_served=1.
REQ-029 Reset forces grant_valid=0, grant_id=0, grant_info=0, int_ack0/1=0, overrun=0, timeout=0, and the timeout counter to 0.
REQ-030 After release, a level already high on upd_req_i is not treated as a rise.

Configuration
REQ-031 Macro MFP_BOT_ARB_TIMEOUT_EN defined: a counter clears on GRANT entry and increments each GRANT cycle.
REQ-032 With the macro defined, at count ACK_TIMEOUT without cpu_ack, the FSM enters IDLE, pulses timeout for one cycle, clears grant_valid and pending[grant_id], updates last_served, and issues no int_ack.
REQ-033 With the macro defined, cpu_ack in the same cycle as expiry takes precedence, so a normal ACK occurs.
REQ-034 Macro undefined: no counter is built, timeout is tied 0, and GRANT waits indefinitely.

Verification
REQ-035 Rise on upd_req0 at cycle 10, bot_info0=32'hA5A5_0001 -> cycle 11 grant_valid=1, grant_id=0, grant_info=32'hA5A5_0001; cpu_ack at cycle 15 -> int_ack0 high at cycle 16 only.
REQ-036 Both reqs rise in the same cycle after reset -> bot 0 granted, then bot 1 granted 3 cycles after bot 0's cpu_ack; next simultaneous pair -> bot 0 again.
REQ-037 Two rises on upd_req1 while bot 0 holds the grant -> overrun=2'b10, one bot 1 grant only; ovr_clr -> overrun=2'b00.
REQ-038 TIMEOUT_EN build with ACK_TIMEOUT=8, no cpu_ack -> timeout pulse 8 cycles after grant, grant_valid=0, int_ack0/1 stay 0.
REQ-039 HRESETn low during GRANT with upd_req1 held high through release -> all outputs 0 and no grant until upd_req1 falls and rises again.
REQ-040 cpu_ack pulsed in IDLE and in ACK -> no state change and no int_ack.
